apb_core_bridge: RTL

- Converts the core's LSU-style data request port (req/gnt/rvalid) into a single APB3 master transaction stream for the SoC peripheral bus.
- Sits directly upstream of the APB peripheral interconnect; its outputs drive the master-side psel, penable, paddr, pwdata and pwrite signals, and it consumes prdata, pready and pslverr.
- One transaction in flight; no buffering beyond the captured request.

---
 rtl/apb_core_bridge.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/apb_core_bridge.sv
// LSU-style req/gnt/rvalid port to APB3 master bridge, one transaction in flight.
// Optional ACCESS-phase timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_core_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr,
  output logic [APB_DATA_WIDTH-1:0]   pwdata,
  output logic                        pwrite,
  output logic                        psel,
  output logic                        penable,
  input  logic [APB_DATA_WIDTH-1:0]   prdata,
  input  logic                        pready,
  input  logic                        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                      state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                        pwrite_q, pwrite_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        err_q, err_d;
  logic [APB_DATA_WIDTH/8-1:0] be_q, be_d;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    be_d       = be_q;
    data_gnt_o = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          paddr_d  = {data_addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
          pwrite_d = data_we_i;
          pwdata_d = data_we_i ? data_wdata_i : '0;
          be_d     = data_be_i;
          psel_d   = 1'b1;
          state_d  = SETUP;
`ifdef APB_BRIDGE_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rdata_d   = pwrite_q ? '0 : prdata;
          err_d     = pslverr;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        // A slave that never answers is reported to the core as an error.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      be_q      <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      be_q      <= be_d;
`ifdef APB_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign paddr         = paddr_q;
  assign pwdata        = pwdata_q;
  assign pwrite        = pwrite_q;
  assign psel          = psel_q;
  assign penable       = penable_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule
